alu_seq_datapath: RTL

- Parametrised, multi-cycle successor to the lab ALU datapath.
- Holds A/B operand buffers and latches the opcode at start.
- Runs one operation through an explicit FSM with configurable latency, then returns the result with a one-cycle alu_done pulse.
- Adds a synchronous reset, a busy indication, an 8-entry opcode set, and a result/flag hold.
- Sits between the ALU control FSM and the register/output stage.

---
 rtl/alu_seq_datapath.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_seq_datapath.sv
// rtl/alu_seq_datapath.sv - multi-cycle ALU datapath with operand buffers, latency FSM and result hold
// Optional saturating ADD/SUB when ALU_SAT_EN is defined.
module alu_seq_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [2:0]            opcode_value,
    input  logic                  store_a,
    input  logic                  store_b,
    input  logic                  start,
    output logic                  busy,
    output logic                  alu_done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_PAR  = 3'b010;
    localparam logic [2:0] OP_COMP = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t                state;
    logic [DATA_WIDTH-1:0] buf_a;
    logic [DATA_WIDTH-1:0] buf_b;
    logic [2:0]            op_q;
    logic [CW-1:0]         cnt;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;

    // Stores are blocked during EXEC, so the buffers double as the operand snapshot.
    assign sum  = {1'b0, buf_a} + {1'b0, buf_b};
    assign diff = {1'b0, buf_a} - {1'b0, buf_b};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[DATA_WIDTH-1:0];
                alu_ovf = sum[DATA_WIDTH];
`ifdef ALU_SAT_EN
                if (sum[DATA_WIDTH]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res = diff[DATA_WIDTH-1:0];
                alu_ovf = diff[DATA_WIDTH];
`ifdef ALU_SAT_EN
                if (diff[DATA_WIDTH]) alu_res = '0;
`endif
            end
            OP_PAR:  alu_res[0] = ^{buf_a, buf_b};
            OP_COMP: begin
                alu_res[1] = (buf_a < buf_b);
                alu_res[0] = (buf_a > buf_b);
            end
            OP_AND:  alu_res = buf_a & buf_b;
            OP_OR:   alu_res = buf_a | buf_b;
            OP_XOR:  alu_res = buf_a ^ buf_b;
            OP_PASS: alu_res = buf_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            buf_a    <= '0;
            buf_b    <= '0;
            op_q     <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            alu_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // One action per edge: store_a, then store_b, then start.
                    state <= S_IDLE;
                    if (store_a) begin
                        buf_a <= alu_data;
                    end else if (store_b) begin
                        buf_b <= alu_data;
                    end else if (start) begin
                        op_q  <= opcode_value;
                        cnt   <= CW'(LATENCY - 1);
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        result   <= alu_res;
                        overflow <= alu_ovf;
                        alu_done <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
